// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the bundled latch/PC control word.
package hazard_ctrl_unit_pkg;

   typedef enum logic [1:0] {RUN, LDSTALL, DWAIT} hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic pc_wen;
      logic ifid_en;
      logic ifid_fl;
      logic idex_en;
      logic idex_fl;
      logic exmem_en;
      logic exmem_fl;
      logic memwb_en;
   } hz_ctrl_t;

   // Canonical control words, one per event class.
   localparam hz_ctrl_t CTRL_RUN    = 8'b1101_0101;
   localparam hz_ctrl_t CTRL_FREEZE = 8'b0000_0000;
   localparam hz_ctrl_t CTRL_STALL  = 8'b0001_1101;
   localparam hz_ctrl_t CTRL_BRANCH = 8'b1111_1101;
   localparam hz_ctrl_t CTRL_JUMP   = 8'b1111_0101;
   localparam hz_ctrl_t CTRL_IMISS  = 8'b0111_0101;

   function automatic fwd_sel_t fwd_pick(input logic exmem_hit, input logic memwb_hit);
      if (exmem_hit)      return FWD_EXMEM;
      else if (memwb_hit) return FWD_MEMWB;
      else                return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Combinational register-match logic: ID-stage hazard hits and EX-stage
// forwarding selects. Register 0 never matches.
module hazard_fwd_sel
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] idex_wsel,
   input  logic             idex_wen,
   input  logic [REG_W-1:0] exmem_wsel,
   input  logic             exmem_wen,
   input  logic [REG_W-1:0] memwb_wsel,
   input  logic             memwb_wen,
   output logic             id_hit_idex,
   output logic             id_hit_exmem,
   output fwd_sel_t         fwd_a,
   output fwd_sel_t         fwd_b
);

   function automatic logic rmatch(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst,
                                   input logic             wen);
      return wen && (src == dst) && (dst != '0);
   endfunction

   assign id_hit_idex  = (id_use_rs && rmatch(id_rs, idex_wsel, idex_wen)) ||
                         (id_use_rt && rmatch(id_rt, idex_wsel, idex_wen));
   assign id_hit_exmem = (id_use_rs && rmatch(id_rs, exmem_wsel, exmem_wen)) ||
                         (id_use_rt && rmatch(id_rt, exmem_wsel, exmem_wen));

   // EX/MEM holds the younger result, so it wins over MEM/WB.
   assign fwd_a = fwd_pick(rmatch(ex_rs, exmem_wsel, exmem_wen),
                           rmatch(ex_rs, memwb_wsel, memwb_wen));
   assign fwd_b = fwd_pick(rmatch(ex_rt, exmem_wsel, exmem_wen),
                           rmatch(ex_rt, memwb_wsel, memwb_wen));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Five-stage pipeline hazard controller: PC/latch control, load-use bubbles,
// data-memory wait freeze, forwarding selects and a saturating stall counter.
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int REG_W          = 5,
   parameter int FORWARD_EN     = 1,
   parameter int LOAD_USE_STALL = 1,
   parameter int CNT_W          = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_access,
   input  logic             branch_taken,
   input  logic             jump_id,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] idex_wsel,
   input  logic [REG_W-1:0] exmem_wsel,
   input  logic [REG_W-1:0] memwb_wsel,
   input  logic             idex_wen,
   input  logic             exmem_wen,
   input  logic             memwb_wen,
   input  logic             idex_memread,
   output logic             pcWEN,
   output logic             IFID_enable,
   output logic             IFID_flush,
   output logic             IDEX_enable,
   output logic             IDEX_flush,
   output logic             EXMEM_enable,
   output logic             EXMEM_flush,
   output logic             MEMWB_enable,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int  LW     = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
   localparam bit  FWD_ON = (FORWARD_EN != 0);

   hz_state_t   state, nxt_state, saved, nxt_saved, eff;
   logic [LW-1:0] cnt, nxt_cnt;
   hz_ctrl_t    ctrl;
   logic        hit_idex, hit_exmem, raw_stall, mem_wait;
   fwd_sel_t    sel_a, sel_b;

   hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_sel (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .idex_wsel    (idex_wsel),
      .idex_wen     (idex_wen),
      .exmem_wsel   (exmem_wsel),
      .exmem_wen    (exmem_wen),
      .memwb_wsel   (memwb_wsel),
      .memwb_wen    (memwb_wen),
      .id_hit_idex  (hit_idex),
      .id_hit_exmem (hit_exmem),
      .fwd_a        (sel_a),
      .fwd_b        (sel_b)
   );

   // Without forwarding, any producer still in EX or MEM must drain first.
   assign raw_stall = FWD_ON ? (idex_memread && hit_idex) : (hit_idex || hit_exmem);

   // The dhit cycle of a wait replays whichever state the wait interrupted.
   assign eff      = (state == DWAIT) ? saved : state;
   assign mem_wait = !dhit && (mem_access || (state == DWAIT));

   always_comb begin
      ctrl      = CTRL_RUN;
      nxt_state = RUN;
      nxt_saved = saved;
      nxt_cnt   = cnt;
      if (mem_wait) begin
         ctrl      = CTRL_FREEZE;
         nxt_state = DWAIT;
         nxt_saved = eff;
      end else if (branch_taken) begin
         ctrl = CTRL_BRANCH;
      end else if (eff == LDSTALL) begin
         ctrl      = CTRL_STALL;
         nxt_cnt   = cnt - 1'b1;
         nxt_state = (cnt == LW'(1)) ? RUN : LDSTALL;
      end else if (raw_stall) begin
         ctrl = CTRL_STALL;
         if (FWD_ON && (LOAD_USE_STALL > 1)) begin
            nxt_state = LDSTALL;
            nxt_cnt   = LW'(LOAD_USE_STALL - 1);
         end
      end else if (jump_id) begin
         ctrl = CTRL_JUMP;
      end else if (!ihit) begin
         ctrl = CTRL_IMISS;
      end
      if (!nRST) ctrl = CTRL_FREEZE;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state        <= RUN;
         saved        <= RUN;
         cnt          <= '0;
         stall_cycles <= '0;
      end else begin
         state <= nxt_state;
         saved <= nxt_saved;
         cnt   <= nxt_cnt;
         if (!ctrl.pc_wen && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign pcWEN        = ctrl.pc_wen;
   assign IFID_enable  = ctrl.ifid_en;
   assign IFID_flush   = ctrl.ifid_fl;
   assign IDEX_enable  = ctrl.idex_en;
   assign IDEX_flush   = ctrl.idex_fl;
   assign EXMEM_enable = ctrl.exmem_en;
   assign EXMEM_flush  = ctrl.exmem_fl;
   assign MEMWB_enable = ctrl.memwb_en;
   assign fwd_a        = (nRST && FWD_ON) ? sel_a : FWD_RF;
   assign fwd_b        = (nRST && FWD_ON) ? sel_b : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding/3-bubble, stall-only and
// 1-bubble/3-bit-counter instances share one stimulus stream.
module tb_hazard_ctrl_unit;

   localparam logic [7:0] C_RUN    = 8'b1101_0101;
   localparam logic [7:0] C_FREEZE = 8'b0000_0000;
   localparam logic [7:0] C_STALL  = 8'b0001_1101;
   localparam logic [7:0] C_BRANCH = 8'b1111_1101;
   localparam logic [7:0] C_JUMP   = 8'b1111_0101;
   localparam logic [7:0] C_IMISS  = 8'b0111_0101;

   logic CLK = 1'b0;
   logic nRST, ihit, dhit, mem_access, branch_taken, jump_id;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, idex_wsel, exmem_wsel, memwb_wsel;
   logic id_use_rs, id_use_rt, idex_wen, exmem_wen, memwb_wen, idex_memread;

   logic p1, ie1, if1, de1, df1, ee1, ef1, me1;
   logic p0, ie0, if0, de0, df0, ee0, ef0, me0;
   logic ps, ies, ifs, des, dfs, ees, efs, mes;
   logic [1:0] fa1, fb1, fa0, fb0, fas, fbs;
   logic [15:0] sc1, sc0;
   logic [2:0]  scs;
   logic [7:0]  c1, c0, cs;

   int total = 0;
   int passed = 0;

   always #5 CLK = ~CLK;

   assign c1 = {p1, ie1, if1, de1, df1, ee1, ef1, me1};
   assign c0 = {p0, ie0, if0, de0, df0, ee0, ef0, me0};
   assign cs = {ps, ies, ifs, des, dfs, ees, efs, mes};

   hazard_ctrl_unit #(.REG_W(5), .FORWARD_EN(1), .LOAD_USE_STALL(3), .CNT_W(16)) u_d1 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_access(mem_access),
      .branch_taken(branch_taken), .jump_id(jump_id), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .idex_wsel(idex_wsel), .exmem_wsel(exmem_wsel), .memwb_wsel(memwb_wsel),
      .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
      .idex_memread(idex_memread), .pcWEN(p1), .IFID_enable(ie1), .IFID_flush(if1),
      .IDEX_enable(de1), .IDEX_flush(df1), .EXMEM_enable(ee1), .EXMEM_flush(ef1),
      .MEMWB_enable(me1), .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1));

   hazard_ctrl_unit #(.REG_W(5), .FORWARD_EN(0), .LOAD_USE_STALL(1), .CNT_W(16)) u_d0 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_access(mem_access),
      .branch_taken(branch_taken), .jump_id(jump_id), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .idex_wsel(idex_wsel), .exmem_wsel(exmem_wsel), .memwb_wsel(memwb_wsel),
      .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
      .idex_memread(idex_memread), .pcWEN(p0), .IFID_enable(ie0), .IFID_flush(if0),
      .IDEX_enable(de0), .IDEX_flush(df0), .EXMEM_enable(ee0), .EXMEM_flush(ef0),
      .MEMWB_enable(me0), .fwd_a(fa0), .fwd_b(fb0), .stall_cycles(sc0));

   hazard_ctrl_unit #(.REG_W(5), .FORWARD_EN(1), .LOAD_USE_STALL(1), .CNT_W(3)) u_ds (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_access(mem_access),
      .branch_taken(branch_taken), .jump_id(jump_id), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .idex_wsel(idex_wsel), .exmem_wsel(exmem_wsel), .memwb_wsel(memwb_wsel),
      .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
      .idex_memread(idex_memread), .pcWEN(ps), .IFID_enable(ies), .IFID_flush(ifs),
      .IDEX_enable(des), .IDEX_flush(dfs), .EXMEM_enable(ees), .EXMEM_flush(efs),
      .MEMWB_enable(mes), .fwd_a(fas), .fwd_b(fbs), .stall_cycles(scs));

   task automatic idle();
      ihit = 1'b1; dhit = 1'b1; mem_access = 1'b0; branch_taken = 1'b0; jump_id = 1'b0;
      id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
      idex_wsel = '0; exmem_wsel = '0; memwb_wsel = '0;
      id_use_rs = 1'b0; id_use_rt = 1'b0;
      idex_wen = 1'b0; exmem_wen = 1'b0; memwb_wen = 1'b0; idex_memread = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic do_reset();
      idle(); nRST = 1'b0; tick(); nRST = 1'b1; #1;
   endtask

   // lw $2 in EX, add in ID reads $2
   task automatic set_load_use();
      idex_memread = 1'b1; idex_wen = 1'b1; idex_wsel = 5'd2;
      id_rs = 5'd2; id_use_rs = 1'b1;
   endtask

   task automatic clear_load();
      idex_memread = 1'b0; idex_wen = 1'b0; idex_wsel = '0;
   endtask

   task automatic test_reset();
      idle(); nRST = 1'b0;
      branch_taken = 1'b1; ex_rs = 5'd4; exmem_wsel = 5'd4; exmem_wen = 1'b1;
      #1;
      total++; if (c1 !== C_FREEZE) $display("FAIL reset_ctl got %b want %b", c1, C_FREEZE); else passed++;
      total++; if (fa1 !== 2'b00) $display("FAIL reset_fwd_a got %b want 00", fa1); else passed++;
      tick(); tick();
      total++; if (sc1 !== 16'd0) $display("FAIL reset_cnt got %0d want 0", sc1); else passed++;
      idle(); nRST = 1'b1; #1;
      total++; if (c1 !== C_RUN) $display("FAIL reset_release_ctl got %b want %b", c1, C_RUN); else passed++;
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use(); #1;
      total++; if (c1 !== C_STALL) $display("FAIL lu_c1 got %b want %b", c1, C_STALL); else passed++;
      total++; if (cs !== C_STALL) $display("FAIL lu1_c1 got %b want %b", cs, C_STALL); else passed++;
      tick();
      total++; if (sc1 !== 16'd1) $display("FAIL lu_cnt1 got %0d want 1", sc1); else passed++;
      clear_load(); #1;
      for (int i = 2; i <= 3; i++) begin
         total++; if (c1 !== C_STALL) $display("FAIL lu_c%0d got %b want %b", i, c1, C_STALL); else passed++;
         if (i == 2) begin
            total++; if (cs !== C_RUN) $display("FAIL lu1_done got %b want %b", cs, C_RUN); else passed++;
         end
         tick();
      end
      total++; if (c1 !== C_RUN) $display("FAIL lu_done got %b want %b", c1, C_RUN); else passed++;
      total++; if (sc1 !== 16'd3) $display("FAIL lu_cnt got %0d want 3", sc1); else passed++;
   endtask

   task automatic test_forwarding();
      do_reset();
      ex_rs = 5'd4; ex_rt = 5'd4;
      exmem_wsel = 5'd4; exmem_wen = 1'b1; memwb_wsel = 5'd4; memwb_wen = 1'b1; #1;
      total++; if (fa1 !== 2'b01) $display("FAIL fwd_exmem got %b want 01", fa1); else passed++;
      total++; if (fb1 !== 2'b01) $display("FAIL fwd_b_exmem got %b want 01", fb1); else passed++;
      total++; if (fa0 !== 2'b00) $display("FAIL fwd_off got %b want 00", fa0); else passed++;
      exmem_wsel = 5'd0; #1;
      total++; if (fa1 !== 2'b10) $display("FAIL fwd_memwb got %b want 10", fa1); else passed++;
      memwb_wen = 1'b0; exmem_wsel = 5'd4; exmem_wen = 1'b0; #1;
      total++; if (fa1 !== 2'b00) $display("FAIL fwd_nowen got %b want 00", fa1); else passed++;
      ex_rs = 5'd0; exmem_wsel = 5'd0; exmem_wen = 1'b1; memwb_wsel = 5'd0; memwb_wen = 1'b1; #1;
      total++; if (fa1 !== 2'b00) $display("FAIL fwd_r0 got %b want 00", fa1); else passed++;
      ex_rt = 5'd9; memwb_wsel = 5'd9; #1;
      total++; if (fb1 !== 2'b10) $display("FAIL fwd_b_memwb got %b want 10", fb1); else passed++;
      total++; if (c1 !== C_RUN) $display("FAIL fwd_ctl got %b want %b", c1, C_RUN); else passed++;
   endtask

   task automatic test_dwait_ldstall();
      do_reset();
      set_load_use(); #1; tick();
      clear_load(); mem_access = 1'b1; dhit = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         total++; if (c1 !== C_FREEZE) $display("FAIL dw_freeze%0d got %b want %b", i, c1, C_FREEZE); else passed++;
         tick();
      end
      dhit = 1'b1; #1;
      total++; if (c1 !== C_STALL) $display("FAIL dw_resume1 got %b want %b", c1, C_STALL); else passed++;
      tick();
      mem_access = 1'b0; #1;
      total++; if (c1 !== C_STALL) $display("FAIL dw_resume2 got %b want %b", c1, C_STALL); else passed++;
      tick();
      total++; if (c1 !== C_RUN) $display("FAIL dw_done got %b want %b", c1, C_RUN); else passed++;
      total++; if (sc1 !== 16'd7) $display("FAIL dw_cnt got %0d want 7", sc1); else passed++;
   endtask

   task automatic test_branch_priority();
      do_reset();
      set_load_use(); branch_taken = 1'b1; #1;
      total++; if (c1 !== C_BRANCH) $display("FAIL br_lu got %b want %b", c1, C_BRANCH); else passed++;
      tick();
      idle(); #1;
      total++; if (c1 !== C_RUN) $display("FAIL br_after got %b want %b", c1, C_RUN); else passed++;
      set_load_use(); #1; tick();
      clear_load(); branch_taken = 1'b1; #1;
      total++; if (c1 !== C_BRANCH) $display("FAIL br_ldstall got %b want %b", c1, C_BRANCH); else passed++;
      tick();
      branch_taken = 1'b0; #1;
      total++; if (c1 !== C_RUN) $display("FAIL br_cancel got %b want %b", c1, C_RUN); else passed++;
   endtask

   task automatic test_stall_only();
      do_reset();
      exmem_wsel = 5'd5; exmem_wen = 1'b1; id_rt = 5'd5; id_use_rt = 1'b1; ex_rt = 5'd5; #1;
      for (int i = 0; i < 3; i++) begin
         total++; if (c0 !== C_STALL) $display("FAIL so_stall%0d got %b want %b", i, c0, C_STALL); else passed++;
         total++; if (fb0 !== 2'b00) $display("FAIL so_fwd%0d got %b want 00", i, fb0); else passed++;
         tick();
      end
      total++; if (c1 !== C_RUN) $display("FAIL so_fwdmode got %b want %b", c1, C_RUN); else passed++;
      exmem_wen = 1'b0; memwb_wsel = 5'd5; memwb_wen = 1'b1; #1;
      total++; if (c0 !== C_RUN) $display("FAIL so_memwb got %b want %b", c0, C_RUN); else passed++;
      idex_wsel = 5'd5; idex_wen = 1'b1; id_use_rt = 1'b0; #1;
      total++; if (c0 !== C_RUN) $display("FAIL so_unused got %b want %b", c0, C_RUN); else passed++;
      id_use_rt = 1'b1; #1;
      total++; if (c0 !== C_STALL) $display("FAIL so_idex got %b want %b", c0, C_STALL); else passed++;
   endtask

   task automatic test_jump_imiss();
      do_reset();
      jump_id = 1'b1; #1;
      total++; if (c1 !== C_JUMP) $display("FAIL jump got %b want %b", c1, C_JUMP); else passed++;
      ihit = 1'b0; #1;
      total++; if (c1 !== C_JUMP) $display("FAIL jump_imiss got %b want %b", c1, C_JUMP); else passed++;
      jump_id = 1'b0; #1;
      total++; if (c1 !== C_IMISS) $display("FAIL imiss got %b want %b", c1, C_IMISS); else passed++;
      ihit = 1'b1; jump_id = 1'b1; set_load_use(); #1;
      total++; if (cs !== C_STALL) $display("FAIL jump_lu got %b want %b", cs, C_STALL); else passed++;
   endtask

   task automatic test_reset_dwait();
      do_reset();
      mem_access = 1'b1; dhit = 1'b0; tick(); tick();
      total++; if (c1 !== C_FREEZE) $display("FAIL rd_wait got %b want %b", c1, C_FREEZE); else passed++;
      nRST = 1'b0; ex_rs = 5'd3; exmem_wsel = 5'd3; exmem_wen = 1'b1; #1;
      total++; if (fa1 !== 2'b00) $display("FAIL rd_fwd got %b want 00", fa1); else passed++;
      tick();
      idle(); nRST = 1'b1; #1;
      total++; if (c1 !== C_RUN) $display("FAIL rd_run got %b want %b", c1, C_RUN); else passed++;
      total++; if (sc1 !== 16'd0) $display("FAIL rd_cnt got %0d want 0", sc1); else passed++;
   endtask

   task automatic test_saturation();
      do_reset();
      ihit = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      total++; if (scs !== 3'd7) $display("FAIL sat_full got %0d want 7", scs); else passed++;
      tick(); tick();
      total++; if (scs !== 3'd7) $display("FAIL sat_hold got %0d want 7", scs); else passed++;
      total++; if (sc1 !== 16'd9) $display("FAIL sat_wide got %0d want 9", sc1); else passed++;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_forwarding();
      test_dwait_ldstall();
      test_branch_priority();
      test_stall_only();
      test_jump_imiss();
      test_reset_dwait();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the five-stage MIPS core: the next generation of the existing hazard unit. Sits beside the datapath and drives PC write-enable, per-latch enable/flush, and EX-stage forwarding selects. Adds a selectable forwarding/stall-only mode, multi-cycle load-use bubbles, a data-memory wait state, and a saturating stall-cycle counter.

## Interface
- REG_W, 5, register-select width
- FORWARD_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = resolve every RAW hazard by stalling
- LOAD_USE_STALL, 1, bubbles per load-use hazard (≥1; forwarding mode only)
- CNT_W, 16, stall counter width

- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- ihit, dhit  in  1  memory ready
- mem_access  in  1  MEM stage has a dmem read or write
- branch_taken  in  1  EX resolved a taken branch
- jump_id  in  1  ID holds j/jal/jr
- id_rs, id_rt  in  REG_W  ID source registers
- id_use_rs, id_use_rt  in  1  source actually read
- ex_rs, ex_rt  in  REG_W  EX operand registers
- idex_wsel, exmem_wsel, memwb_wsel  in  REG_W  destination registers
- idex_wen, exmem_wen, memwb_wen  in  1  destination written
- idex_memread  in  1  EX holds a load
- pcWEN  out  1  PC update
- IFID_enable, IFID_flush, IDEX_enable, IDEX_flush, EXMEM_enable, EXMEM_flush, MEMWB_enable  out  1  latch control
- fwd_a, fwd_b  out  2  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- stall_cycles  out  CNT_W  saturating count of cycles with pcWEN=0

## Operation
- Matches: a register match requires equal selects, wen=1, select≠0.
- States: RUN, LDSTALL, DWAIT. Outputs are combinational from state and inputs.
- Event priority (highest first): DWAIT/mem wait > branch_taken > RAW/load-use stall > jump_id > ihit miss.
- Mem wait: mem_access && !dhit → all enables 0, pcWEN 0, no flushes; enter DWAIT, remembering prior state and counter. Stay until dhit; dhit cycle behaves as the remembered state, then return to it. Counter frozen while in DWAIT.
- Branch: branch_taken → IFID_flush=1, IDEX_flush=1, pcWEN=1, all enables 1; cancels any LDSTALL (next state RUN).
- Load-use (FORWARD_EN=1): idex_memread && idex_wsel matches a used ID source → pcWEN=0, IFID_enable=0, IDEX_flush=1, rest advance. If LOAD_USE_STALL>1 go LDSTALL with cnt=LOAD_USE_STALL-1; LDSTALL stalls identically, decrements cnt, returns to RUN at edge where cnt==1.
- Stall-only (FORWARD_EN=0): used ID source matches idex_wsel or exmem_wsel → same stall outputs, held combinationally while match persists; fwd_a/fwd_b tied 00; LDSTALL unused. MEM/WB needs no stall (regfile writes first).
- Forwarding: fwd_a from ex_rs, fwd_b from ex_rt; EX/MEM match → 01, else MEM/WB match → 10, else 00. Register 0 never forwarded.
- Jump: jump_id (no stall) → IFID_flush=1, pcWEN=1.
- ihit=0 (no higher event) → pcWEN=0, IFID_flush=1, later stages advance.
- No event: pcWEN=1, all enables 1, flushes 0.
- stall_cycles increments each cycle pcWEN=0 with nRST=1; holds at all-ones.

## Timing
- Reset: posedge with nRST=0 → state RUN, cnt 0, stall_cycles 0. While nRST=0 outputs forced: pcWEN 0, enables 0, flushes 0, fwd 00.
- All latch/PC controls zero-latency combinational; stall_cycles updates one edge after the stalled cycle.
- Load-use: exactly LOAD_USE_STALL bubble cycles, plus any DWAIT cycles.
- Reset mid-LDSTALL/DWAIT returns to RUN, no residual stall.

## Structure
- cpu_types_pkg gains hz_state_t (RUN, LDSTALL, DWAIT) and fwd_sel_t (FWD_RF, FWD_EXMEM, FWD_MEMWB).
- hazard_unit_if extended with the new ports.
- Sub-module hazard_fwd_sel: purely combinational match/forward logic, instantiated once, outputs tied off when FORWARD_EN=0.

## Test plan
- lw $2 in EX, ID add uses $2, LOAD_USE_STALL=3 → pcWEN=0 three cycles, IDEX_flush=1 each, stall_cycles=3.
- EX rs=$4, exmem_wsel=$4 and memwb_wsel=$4 → fwd_a=01; exmem_wsel=$0 with memwb match → fwd_a=10.
- mem_access, dhit low 4 cycles during LDSTALL cnt=2 → full freeze 4 cycles, then remaining 2 stall cycles.
- branch_taken with load-use same cycle → IFID/IDEX flush, pcWEN=1, state RUN.
- FORWARD_EN=0, exmem_wsel=$5 matches id_rt → stall until match clears, fwd 00 throughout.
- nRST low during DWAIT → next cycle RUN, stall_cycles 0, outputs idle values while low.
